// File: rtl/enemy_bullet_pool_pkg.sv
// -----------------------------------------------------------------------------
// enemy_bullet_pool_pkg
// Shared screen geometry, coordinate widths and heat limits for the enemy
// projectile stage, plus a width helper used by its sub-modules.
// No ports (package).
// -----------------------------------------------------------------------------
package enemy_bullet_pool_pkg;

    localparam int SCREEN_W      = 160;
    localparam int DEF_SCREEN_H  = 120;
    localparam int DEF_X_W       = $clog2(SCREEN_W);      // 8
    localparam int DEF_Y_W       = $clog2(DEF_SCREEN_H);  // 7

    localparam int              HEAT_W   = 4;
    localparam logic [HEAT_W-1:0] HEAT_MAX = 4'hF;

    // Counter/index width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/first_free_slot.sv
// -----------------------------------------------------------------------------
// first_free_slot
// Priority encoder: index of the lowest-numbered slot whose valid bit is 0.
// Ports:
//   valid in  [N]  : slot occupancy
//   idx   out [IW] : lowest free slot (0 when none free)
//   found out      : at least one slot is free
// -----------------------------------------------------------------------------
module first_free_slot
    import enemy_bullet_pool_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    output logic [IW-1:0] idx,
    output logic          found
);

    // NOTE: outputs get a default before the loop so no path leaves them
    // unassigned; a missing default infers a latch.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Scan downward so the lowest free index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                idx   = IW'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Free-running counter 0..DIV-1; tick is high for the one cycle in which the
// counter wraps.
// Ports:
//   clock  in  : system clock
//   resetn in  : synchronous active-low reset (counter back to 0)
//   tick   out : one-cycle pulse every DIV cycles
// -----------------------------------------------------------------------------
module tick_divider
    import enemy_bullet_pool_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic resetn,
    output logic tick
);

    localparam int            CW   = clog2_min1(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/enemy_bullet_pool.sv
// -----------------------------------------------------------------------------
// enemy_bullet_pool
// Spawns enemy bullets into a fixed slot pool on enemy_shoot, moves them down
// on a move tick, retires them at the bottom edge or on collision clear, and
// tracks gun heat (gun_cooldown) for the shoot-decision logic.
// Ports:
//   clock, resetn           : clock and synchronous active-low reset
//   enemy_shoot             : level fire request
//   enemy_x, enemy_y        : muzzle position
//   bullet_clear[NB]        : per-slot retire request
//   bullet_valid[NB]        : slot occupied
//   bullet_x / bullet_y     : packed slot coordinates, slot i at [i*W +: W]
//   gun_cooldown[4]         : heat 0..15
//   pool_full               : all slots valid (combinational)
//   spawn_drop              : one-cycle pulse when a spawn found no free slot
// -----------------------------------------------------------------------------
module enemy_bullet_pool
    import enemy_bullet_pool_pkg::*;
#(
    parameter int NUM_BULLETS = 4,
    parameter int X_W         = DEF_X_W,
    parameter int Y_W         = DEF_Y_W,
    parameter int SCREEN_H    = DEF_SCREEN_H,
    parameter int STEP        = 1,
    parameter int MOVE_DIV    = 833333,
    parameter int FIRE_GAP    = 4166666,
    parameter int COOL_DIV    = 12500000
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       enemy_shoot,
    input  logic [X_W-1:0]             enemy_x,
    input  logic [Y_W-1:0]             enemy_y,
    input  logic [NUM_BULLETS-1:0]     bullet_clear,
    output logic [NUM_BULLETS-1:0]     bullet_valid,
    output logic [NUM_BULLETS*X_W-1:0] bullet_x,
    output logic [NUM_BULLETS*Y_W-1:0] bullet_y,
    output logic [HEAT_W-1:0]          gun_cooldown,
    output logic                       pool_full,
    output logic                       spawn_drop
);

    localparam int           IW        = clog2_min1(NUM_BULLETS);
    localparam int           GW        = clog2_min1(FIRE_GAP);
    localparam logic [Y_W:0] Y_LIMIT   = (Y_W + 1)'(SCREEN_H);
    localparam logic [Y_W:0] Y_STEP    = (Y_W + 1)'(STEP);

    logic [NUM_BULLETS-1:0] valid_q;
    logic [X_W-1:0]         slot_x  [NUM_BULLETS];
    logic [Y_W-1:0]         slot_y  [NUM_BULLETS];
    logic [Y_W:0]           moved_y [NUM_BULLETS];
    logic [GW-1:0]          gap_cnt;
    logic [HEAT_W-1:0]      heat;

    logic          move_tick;
    logic          cool_tick;
    logic [IW-1:0] free_idx;
    logic          free_found;
    logic          spawn_req;
    logic          spawn_ok;

    tick_divider #(.DIV(MOVE_DIV)) u_move_div (
        .clock  (clock),
        .resetn (resetn),
        .tick   (move_tick)
    );

    tick_divider #(.DIV(COOL_DIV)) u_cool_div (
        .clock  (clock),
        .resetn (resetn),
        .tick   (cool_tick)
    );

    // Uses start-of-cycle occupancy, so a slot cleared this cycle is only
    // offered to a spawn on the following cycle.
    first_free_slot #(.N(NUM_BULLETS), .IW(IW)) u_free (
        .valid (valid_q),
        .idx   (free_idx),
        .found (free_found)
    );

    assign spawn_req = enemy_shoot && (gap_cnt == '0);
    assign spawn_ok  = spawn_req && free_found;

    // One extra bit so a step past the bottom is seen instead of wrapping.
    always_comb begin
        for (int i = 0; i < NUM_BULLETS; i++) begin
            moved_y[i] = {1'b0, slot_y[i]} + Y_STEP;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            valid_q    <= '0;
            gap_cnt    <= '0;
            heat       <= '0;
            spawn_drop <= 1'b0;
            // NOTE: the slot coordinate arrays are reset too because their
            // values are visible on bullet_x/bullet_y and must read 0 after
            // reset; pure storage with a valid bit would not need this.
            for (int i = 0; i < NUM_BULLETS; i++) begin
                slot_x[i] <= '0;
                slot_y[i] <= '0;
            end
        end else begin
            spawn_drop <= spawn_req && !free_found;

            // A dropped spawn does not restart the gap.
            if (spawn_ok) begin
                gap_cnt <= GW'(FIRE_GAP - 1);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end

            // Spawn and cool tick together cancel out.
            if (spawn_ok && !cool_tick) begin
                if (heat != HEAT_MAX) heat <= heat + HEAT_W'(1);
            end else if (cool_tick && !spawn_ok) begin
                if (heat != '0) heat <= heat - HEAT_W'(1);
            end

            for (int i = 0; i < NUM_BULLETS; i++) begin
                if (bullet_clear[i] && valid_q[i]) begin
                    valid_q[i] <= 1'b0;
                end else if (spawn_ok && (free_idx == IW'(i))) begin
                    // Freshly spawned slot is not moved on this cycle.
                    valid_q[i] <= 1'b1;
                    slot_x[i]  <= enemy_x;
                    slot_y[i]  <= enemy_y + Y_W'(1);
                end else if (move_tick && valid_q[i]) begin
                    if (moved_y[i] >= Y_LIMIT) begin
                        valid_q[i] <= 1'b0;
                    end else begin
                        slot_y[i] <= moved_y[i][Y_W-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_BULLETS; i++) begin
            bullet_x[i*X_W +: X_W] = slot_x[i];
            bullet_y[i*Y_W +: Y_W] = slot_y[i];
        end
    end

    assign bullet_valid = valid_q;
    assign gun_cooldown = heat;
    assign pool_full    = &valid_q;

endmodule

// File: tb/tb_enemy_bullet_pool.sv
// -----------------------------------------------------------------------------
// tb_enemy_bullet_pool
// Directed bench for enemy_bullet_pool. dut_a (FIRE_GAP=2, MOVE_DIV=4, slow
// cooling) covers spawning, gap, movement, clears and reset; dut_h
// (FIRE_GAP=1, COOL_DIV=4) covers heat saturation and cooling.
// Edge k below means the k-th rising edge after reset is released.
// -----------------------------------------------------------------------------
module tb_enemy_bullet_pool;

    logic       clock = 1'b0;
    logic       resetn;
    logic       enemy_shoot;
    logic [7:0] enemy_x;
    logic [6:0] enemy_y;
    logic [3:0] bullet_clear;

    logic [3:0]  bullet_valid;
    logic [31:0] bullet_x;
    logic [27:0] bullet_y;
    logic [3:0]  gun_cooldown;
    logic        pool_full;
    logic        spawn_drop;

    logic        shoot_h;
    logic [3:0]  clear_h;
    logic [3:0]  h_valid;
    logic [31:0] h_x;
    logic [27:0] h_y;
    logic [3:0]  h_heat;
    logic        h_full;
    logic        h_drop;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clock = ~clock;

    enemy_bullet_pool #(
        .NUM_BULLETS(4), .X_W(8), .Y_W(7), .SCREEN_H(120), .STEP(1),
        .MOVE_DIV(4), .FIRE_GAP(2), .COOL_DIV(100000)
    ) dut_a (
        .clock        (clock),
        .resetn       (resetn),
        .enemy_shoot  (enemy_shoot),
        .enemy_x      (enemy_x),
        .enemy_y      (enemy_y),
        .bullet_clear (bullet_clear),
        .bullet_valid (bullet_valid),
        .bullet_x     (bullet_x),
        .bullet_y     (bullet_y),
        .gun_cooldown (gun_cooldown),
        .pool_full    (pool_full),
        .spawn_drop   (spawn_drop)
    );

    enemy_bullet_pool #(
        .NUM_BULLETS(4), .X_W(8), .Y_W(7), .SCREEN_H(120), .STEP(1),
        .MOVE_DIV(1000), .FIRE_GAP(1), .COOL_DIV(4)
    ) dut_h (
        .clock        (clock),
        .resetn       (resetn),
        .enemy_shoot  (shoot_h),
        .enemy_x      (enemy_x),
        .enemy_y      (enemy_y),
        .bullet_clear (clear_h),
        .bullet_valid (h_valid),
        .bullet_x     (h_x),
        .bullet_y     (h_y),
        .gun_cooldown (h_heat),
        .pool_full    (h_full),
        .spawn_drop   (h_drop)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn       = 1'b0;
        enemy_shoot  = 1'b0;
        shoot_h      = 1'b0;
        bullet_clear = '0;
        clear_h      = '0;
        enemy_x      = '0;
        enemy_y      = '0;
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (bullet_valid !== 4'b0000) $display("FAIL reset_valid got %b want %b", bullet_valid, 4'b0000); else pass_cnt++;
        total_cnt++; if (bullet_x !== 32'd0) $display("FAIL reset_x got %h want %h", bullet_x, 32'd0); else pass_cnt++;
        total_cnt++; if (bullet_y !== 28'd0) $display("FAIL reset_y got %h want %h", bullet_y, 28'd0); else pass_cnt++;
        total_cnt++; if (gun_cooldown !== 4'd0) $display("FAIL reset_heat got %0d want %0d", gun_cooldown, 0); else pass_cnt++;
        total_cnt++; if ({pool_full, spawn_drop} !== 2'b00) $display("FAIL reset_flags got %b want %b", {pool_full, spawn_drop}, 2'b00); else pass_cnt++;
    endtask

    task automatic test_single_spawn();
        do_reset();
        enemy_shoot = 1'b1; enemy_x = 8'd40; enemy_y = 7'd10;
        step();                                   // edge 1: spawn
        enemy_shoot = 1'b0;
        total_cnt++; if (bullet_valid !== 4'b0001) $display("FAIL spawn_valid got %b want %b", bullet_valid, 4'b0001); else pass_cnt++;
        total_cnt++; if (bullet_x[7:0] !== 8'd40) $display("FAIL spawn_x got %0d want %0d", bullet_x[7:0], 40); else pass_cnt++;
        total_cnt++; if (bullet_y[6:0] !== 7'd11) $display("FAIL spawn_y got %0d want %0d", bullet_y[6:0], 11); else pass_cnt++;
        total_cnt++; if (gun_cooldown !== 4'd1) $display("FAIL spawn_heat got %0d want %0d", gun_cooldown, 1); else pass_cnt++;
        repeat (3) step();                        // edge 4: move tick
        total_cnt++; if (bullet_y[6:0] !== 7'd12) $display("FAIL move_y got %0d want %0d", bullet_y[6:0], 12); else pass_cnt++;
    endtask

    task automatic test_fire_gap();
        do_reset();
        enemy_shoot = 1'b1; enemy_x = 8'd5; enemy_y = 7'd20;
        step();                                   // edge 1
        total_cnt++; if (bullet_valid !== 4'b0001) $display("FAIL gap_e1 got %b want %b", bullet_valid, 4'b0001); else pass_cnt++;
        step();                                   // edge 2: gap blocks
        total_cnt++; if (bullet_valid !== 4'b0001) $display("FAIL gap_e2 got %b want %b", bullet_valid, 4'b0001); else pass_cnt++;
        step();                                   // edge 3
        total_cnt++; if (bullet_valid !== 4'b0011) $display("FAIL gap_e3 got %b want %b", bullet_valid, 4'b0011); else pass_cnt++;
        repeat (2) step();                        // edge 5
        total_cnt++; if (bullet_valid !== 4'b0111) $display("FAIL gap_e5 got %b want %b", bullet_valid, 4'b0111); else pass_cnt++;
        repeat (2) step();                        // edge 7
        total_cnt++; if (bullet_valid !== 4'b1111) $display("FAIL gap_e7 got %b want %b", bullet_valid, 4'b1111); else pass_cnt++;
        total_cnt++; if (pool_full !== 1'b1) $display("FAIL pool_full got %b want %b", pool_full, 1'b1); else pass_cnt++;
        total_cnt++; if (gun_cooldown !== 4'd4) $display("FAIL gap_heat got %0d want %0d", gun_cooldown, 4); else pass_cnt++;
        step();                                   // edge 8: still in gap
        total_cnt++; if (spawn_drop !== 1'b0) $display("FAIL drop_e8 got %b want %b", spawn_drop, 1'b0); else pass_cnt++;
        step();                                   // edge 9: request, no slot
        total_cnt++; if (spawn_drop !== 1'b1) $display("FAIL drop_e9 got %b want %b", spawn_drop, 1'b1); else pass_cnt++;
        total_cnt++; if (gun_cooldown !== 4'd4) $display("FAIL drop_heat got %0d want %0d", gun_cooldown, 4); else pass_cnt++;
        enemy_shoot = 1'b0;
        step();                                   // edge 10
        total_cnt++; if (spawn_drop !== 1'b0) $display("FAIL drop_e10 got %b want %b", spawn_drop, 1'b0); else pass_cnt++;
    endtask

    task automatic test_bottom_edge();
        do_reset();
        repeat (3) step();                        // edges 1..3 idle
        enemy_shoot = 1'b1; enemy_x = 8'd3; enemy_y = 7'd118;
        step();                                   // edge 4: spawn + move tick
        enemy_shoot = 1'b0;
        total_cnt++; if ({bullet_valid, bullet_y[6:0]} !== {4'b0001, 7'd119}) $display("FAIL edge_spawn got %b/%0d want 0001/119", bullet_valid, bullet_y[6:0]); else pass_cnt++;
        repeat (3) step();                        // edge 7
        total_cnt++; if ({bullet_valid, bullet_y[6:0]} !== {4'b0001, 7'd119}) $display("FAIL edge_hold got %b/%0d want 0001/119", bullet_valid, bullet_y[6:0]); else pass_cnt++;
        step();                                   // edge 8: move tick retires
        total_cnt++; if ({bullet_valid, bullet_y[6:0]} !== {4'b0000, 7'd119}) $display("FAIL edge_retire got %b/%0d want 0000/119", bullet_valid, bullet_y[6:0]); else pass_cnt++;
    endtask

    task automatic test_clear_and_spawn();
        do_reset();
        enemy_shoot = 1'b1; enemy_x = 8'd11; enemy_y = 7'd30;
        step(); step();                           // edge 2
        enemy_x = 8'd22;
        step(); step();                           // edge 4
        enemy_x = 8'd33;
        step();                                   // edge 5: slots 0..2
        enemy_shoot = 1'b0; bullet_clear = 4'b1000;
        step();                                   // edge 6: clear of invalid slot
        total_cnt++; if (bullet_valid !== 4'b0111) $display("FAIL clr_invalid got %b want %b", bullet_valid, 4'b0111); else pass_cnt++;
        enemy_shoot = 1'b1; bullet_clear = 4'b0010; enemy_x = 8'd66;
        step();                                   // edge 7: clear slot1, spawn slot3
        total_cnt++; if (bullet_valid !== 4'b1101) $display("FAIL clr_spawn got %b want %b", bullet_valid, 4'b1101); else pass_cnt++;
        total_cnt++; if (bullet_x[31:24] !== 8'd66) $display("FAIL clr_x3 got %0d want %0d", bullet_x[31:24], 66); else pass_cnt++;
        bullet_clear = 4'b0000; enemy_x = 8'd77;
        step();                                   // edge 8: gap
        total_cnt++; if (bullet_valid !== 4'b1101) $display("FAIL clr_gap got %b want %b", bullet_valid, 4'b1101); else pass_cnt++;
        step();                                   // edge 9: refill slot1
        enemy_shoot = 1'b0;
        total_cnt++; if (bullet_valid !== 4'b1111) $display("FAIL refill_valid got %b want %b", bullet_valid, 4'b1111); else pass_cnt++;
        total_cnt++; if (bullet_x[15:8] !== 8'd77) $display("FAIL refill_x1 got %0d want %0d", bullet_x[15:8], 77); else pass_cnt++;
    endtask

    task automatic test_reset_mid_flight();
        do_reset();
        enemy_shoot = 1'b1; enemy_x = 8'd1; enemy_y = 7'd40;
        repeat (5) step();                        // slots 0..2 loaded
        enemy_shoot = 1'b0;
        total_cnt++; if (bullet_valid !== 4'b0111) $display("FAIL mid_pre got %b want %b", bullet_valid, 4'b0111); else pass_cnt++;
        resetn = 1'b0;
        step();
        total_cnt++; if (bullet_valid !== 4'b0000) $display("FAIL mid_valid got %b want %b", bullet_valid, 4'b0000); else pass_cnt++;
        total_cnt++; if ({bullet_x, bullet_y} !== 60'd0) $display("FAIL mid_xy got %h want %h", {bullet_x, bullet_y}, 60'd0); else pass_cnt++;
        total_cnt++; if (gun_cooldown !== 4'd0) $display("FAIL mid_heat got %0d want %0d", gun_cooldown, 0); else pass_cnt++;
        resetn = 1'b1; enemy_shoot = 1'b1; enemy_x = 8'd9; enemy_y = 7'd50;
        step();                                   // first edge after release
        enemy_shoot = 1'b0;
        total_cnt++; if ({bullet_valid, bullet_y[6:0]} !== {4'b0001, 7'd51}) $display("FAIL mid_respawn got %b/%0d want 0001/51", bullet_valid, bullet_y[6:0]); else pass_cnt++;
        total_cnt++; if (gun_cooldown !== 4'd1) $display("FAIL mid_reheat got %0d want %0d", gun_cooldown, 1); else pass_cnt++;
    endtask

    // Shooting every edge with alternating slot clears; cool ticks land on
    // edges that are multiples of 4 and cancel that edge's spawn.
    task automatic test_heat();
        do_reset();
        shoot_h = 1'b1; clear_h = 4'b1111;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (e == 3) begin
                total_cnt++; if (h_heat !== 4'd3) $display("FAIL heat_e3 got %0d want %0d", h_heat, 3); else pass_cnt++;
            end
            if (e == 4) begin
                total_cnt++; if (h_heat !== 4'd3) $display("FAIL heat_cancel got %0d want %0d", h_heat, 3); else pass_cnt++;
            end
        end
        total_cnt++; if (h_heat !== 4'd15) $display("FAIL heat_sat got %0d want %0d", h_heat, 15); else pass_cnt++;
        shoot_h = 1'b0; clear_h = 4'b0000;
        repeat (3) step();                        // edge 23
        total_cnt++; if (h_heat !== 4'd15) $display("FAIL heat_e23 got %0d want %0d", h_heat, 15); else pass_cnt++;
        step();                                   // edge 24
        total_cnt++; if (h_heat !== 4'd14) $display("FAIL heat_e24 got %0d want %0d", h_heat, 14); else pass_cnt++;
        repeat (55) step();                       // edge 79
        total_cnt++; if (h_heat !== 4'd1) $display("FAIL heat_e79 got %0d want %0d", h_heat, 1); else pass_cnt++;
        step();                                   // edge 80
        total_cnt++; if (h_heat !== 4'd0) $display("FAIL heat_e80 got %0d want %0d", h_heat, 0); else pass_cnt++;
        repeat (8) step();                        // edge 88: floored
        total_cnt++; if (h_heat !== 4'd0) $display("FAIL heat_floor got %0d want %0d", h_heat, 0); else pass_cnt++;
    endtask

    initial begin
        resetn       = 1'b0;
        enemy_shoot  = 1'b0;
        shoot_h      = 1'b0;
        enemy_x      = '0;
        enemy_y      = '0;
        bullet_clear = '0;
        clear_h      = '0;
        repeat (2) step();
        test_reset();
        test_single_spawn();
        test_fire_gap();
        test_bottom_edge();
        test_clear_and_spawn();
        test_reset_mid_flight();
        test_heat();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
